// File: rtl/lsu_access_ctrl.sv
// Load/store access controller for the MEM stage.
// Computes the effective address and checks its alignment. It generates store lane
// strobes and shifted data, and runs the addr_ok/data_ok bus handshake.
// Load data is registered when data_ok arrives, then extracted and extended.
// A flush either withdraws a request that the bus has not accepted, or drains an
// accepted one by discarding its response.
module lsu_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      in_read,
    input  logic                      in_write,
    input  logic                      in_unsigned,
    input  logic [1:0]                in_msize,
    input  logic [ADDR_WIDTH-1:0]     in_base,
    input  logic [ADDR_WIDTH-1:0]     in_offset,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    output logic                      stall,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_rdata,
    output logic                      out_adel,
    output logic                      out_ades,
    output logic [ADDR_WIDTH-1:0]     out_badvaddr,
    output logic                      dreq_valid,
    output logic [ADDR_WIDTH-1:0]     dreq_addr,
    output logic [1:0]                dreq_size,
    output logic [DATA_WIDTH/8-1:0]   dreq_strobe,
    output logic [DATA_WIDTH-1:0]     dreq_data,
    input  logic                      dresp_addr_ok,
    input  logic                      dresp_data_ok,
    input  logic [DATA_WIDTH-1:0]     dresp_data
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    rd_q;
    logic                    wr_q;
    logic                    uns_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    adel_q;
    logic                    ades_q;
    logic [ADDR_WIDTH-1:0]   badvaddr_q;

    logic [ADDR_WIDTH-1:0]   addr_s;
    logic                    misaligned_s;
    logic                    accept_s;
    logic [LB-1:0]           lane_q_s;

    // Shift the addressed lane down, keep (8 << size) bits and sign/zero extend.
    // A width equal to or above DATA_WIDTH leaves every bit kept (pass-through).
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] data,
        input logic [LB-1:0]         lane,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] keep;
        logic [7:0]            w;
        logic                  sbit;
        sh   = data >> {lane, 3'b000};
        w    = 8'd8 << size;
        keep = ~({DATA_WIDTH{1'b1}} << w);
        sbit = |(sh & ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << (w - 8'd1)));
        return (sh & keep) | (~keep & {DATA_WIDTH{sbit & ~uns}});
    endfunction

    // Byte enables: (2^size) ones shifted up to the lane, truncated to the bus width.
    function automatic logic [NB-1:0] store_strobe(
        input logic [1:0]    size,
        input logic [LB-1:0] lane
    );
        logic [15:0] m;
        m = (16'd1 << (5'd1 << size)) - 16'd1;
        m = m << lane;
        return m[NB-1:0];
    endfunction

    assign addr_s       = in_base + in_offset;
    assign misaligned_s = ((in_msize == 2'd3) && (DATA_WIDTH == 32)) ||
                          ((addr_s[2:0] & ((3'd1 << in_msize) - 3'd1)) != 3'd0);
    assign accept_s     = (state_q == ST_IDLE) & in_valid & (in_read | in_write) & ~flush;
    assign lane_q_s     = addr_q[LB-1:0];

    // Access sequencer: capture on accept, handshake with the bus, drain on flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            size_q     <= 2'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            uns_q      <= 1'b0;
            wdata_q    <= {DATA_WIDTH{1'b0}};
            rdata_q    <= {DATA_WIDTH{1'b0}};
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_q  <= addr_s;
                        size_q  <= in_msize;
                        rd_q    <= in_read;
                        wr_q    <= in_write;
                        uns_q   <= in_unsigned;
                        wdata_q <= in_wdata;
                        rdata_q <= {DATA_WIDTH{1'b0}};
                        if (misaligned_s) begin
                            adel_q     <= in_read;
                            ades_q     <= in_write;
                            badvaddr_q <= addr_s;
                            state_q    <= ST_DONE;
                        end else begin
                            adel_q     <= 1'b0;
                            ades_q     <= 1'b0;
                            badvaddr_q <= {ADDR_WIDTH{1'b0}};
                            state_q    <= ST_REQ;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        // An accepted request still owes a response that must be drained.
                        if (dresp_addr_ok && !dresp_data_ok) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (dresp_addr_ok && dresp_data_ok) begin
                        rdata_q <= rd_q ? load_extract(dresp_data, lane_q_s, size_q, uns_q)
                                        : {DATA_WIDTH{1'b0}};
                        state_q <= ST_DONE;
                    end else if (dresp_addr_ok) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (dresp_data_ok) begin
                        if (flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            rdata_q <= rd_q ? load_extract(dresp_data, lane_q_s, size_q, uns_q)
                                            : {DATA_WIDTH{1'b0}};
                            state_q <= ST_DONE;
                        end
                    end else begin
                        state_q <= flush ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_DRAIN: begin
                    state_q <= dresp_data_ok ? ST_IDLE : ST_DRAIN;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the completion cycle kills the pulse in that same cycle.
    assign out_valid    = (state_q == ST_DONE) & ~flush;
    assign out_rdata    = rdata_q;
    assign out_adel     = adel_q & out_valid;
    assign out_ades     = ades_q & out_valid;
    assign out_badvaddr = badvaddr_q;
    assign stall        = accept_s | (state_q == ST_REQ) | (state_q == ST_WAIT) |
                          (state_q == ST_DRAIN);

    assign dreq_valid   = (state_q == ST_REQ);
    assign dreq_addr    = addr_q;
    assign dreq_size    = size_q;
    assign dreq_strobe  = wr_q ? store_strobe(size_q, lane_q_s) : {NB{1'b0}};
    assign dreq_data    = wdata_q << {lane_q_s, 3'b000};

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed bench for lsu_access_ctrl: a 32-bit and a 64-bit instance share the
// control/address inputs. Inputs are driven at the falling edge and outputs are
// compared 1ns later.
module tb_lsu_access_ctrl;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_read;
    logic        in_write;
    logic        in_unsigned;
    logic [1:0]  in_msize;
    logic [31:0] in_base;
    logic [31:0] in_offset;
    logic [31:0] wdata32;
    logic [63:0] wdata64;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rsp32;
    logic [63:0] rsp64;

    logic        stall32, ov32, adel32, ades32, dv32;
    logic [31:0] rd32, bva32, da32, dd32;
    logic [1:0]  dsz32;
    logic [3:0]  dst32;

    logic        stall64, ov64, adel64, ades64, dv64;
    logic [63:0] rd64, dd64;
    logic [31:0] bva64, da64;
    logic [1:0]  dsz64;
    logic [7:0]  dst64;

    int n_checks;
    int n_errors;

    lsu_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_read(in_read), .in_write(in_write),
        .in_unsigned(in_unsigned), .in_msize(in_msize),
        .in_base(in_base), .in_offset(in_offset), .in_wdata(wdata32),
        .stall(stall32), .out_valid(ov32), .out_rdata(rd32),
        .out_adel(adel32), .out_ades(ades32), .out_badvaddr(bva32),
        .dreq_valid(dv32), .dreq_addr(da32), .dreq_size(dsz32),
        .dreq_strobe(dst32), .dreq_data(dd32),
        .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok), .dresp_data(rsp32)
    );

    lsu_access_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_read(in_read), .in_write(in_write),
        .in_unsigned(in_unsigned), .in_msize(in_msize),
        .in_base(in_base), .in_offset(in_offset), .in_wdata(wdata64),
        .stall(stall64), .out_valid(ov64), .out_rdata(rd64),
        .out_adel(adel64), .out_ades(ades64), .out_badvaddr(bva64),
        .dreq_valid(dv64), .dreq_addr(da64), .dreq_size(dsz64),
        .dreq_strobe(dst64), .dreq_data(dd64),
        .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok), .dresp_data(rsp64)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge (input-drive point).
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic uns, input logic [1:0] sz,
                           input logic [31:0] base, input logic [31:0] off);
        in_valid    = 1'b1;
        in_read     = rd;
        in_write    = wr;
        in_unsigned = uns;
        in_msize    = sz;
        in_base     = base;
        in_offset   = off;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0; in_unsigned = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        idle_inputs();
        in_msize = 2'd0; in_base = 32'd0; in_offset = 32'd0;
        wdata32 = 32'd0; wdata64 = 64'd0; rsp32 = 32'd0; rsp64 = 64'd0;

        // ---------------- reset state
        next_cyc(); next_cyc(); settle();
        check_eq("rst_stall", {63'd0, stall32}, 64'd0);
        check_eq("rst_ovalid", {63'd0, ov32}, 64'd0);
        check_eq("rst_dvalid", {63'd0, dv32}, 64'd0);
        check_eq("rst_rdata", {32'd0, rd32}, 64'd0);
        next_cyc();
        resetn = 1'b1;

        // ---------------- lb signed at 0x1003, single-cycle response
        next_cyc();
        present(1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_1000, 32'd3);
        settle();
        check_eq("lb_accept_stall", {63'd0, stall32}, 64'd1);
        check_eq("lb_accept_noreq", {63'd0, dv32}, 64'd0);
        next_cyc();
        addr_ok = 1'b1; data_ok = 1'b1; rsp32 = 32'h80FF_0000;
        settle();
        check_eq("lb_dvalid", {63'd0, dv32}, 64'd1);
        check_eq("lb_daddr", {32'd0, da32}, 64'h1003);
        check_eq("lb_strobe", {60'd0, dst32}, 64'd0);
        check_eq("lb_stall_req", {63'd0, stall32}, 64'd1);
        next_cyc();
        idle_inputs(); rsp32 = 32'd0;
        settle();
        check_eq("lb_ovalid", {63'd0, ov32}, 64'd1);
        check_eq("lb_rdata", {32'd0, rd32}, 64'hFFFF_FF80);
        check_eq("lb_stall_done", {63'd0, stall32}, 64'd0);
        next_cyc(); settle();
        check_eq("lb_pulse_end", {63'd0, ov32}, 64'd0);

        // ---------------- sh at 0x2002, addr_ok delayed 3 cycles, data_ok 2 later
        next_cyc();
        present(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_2000, 32'd2);
        wdata32 = 32'h0000_BEEF;
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            addr_ok = (i == 3);
            settle();
            check_eq("sh_dvalid", {63'd0, dv32}, 64'd1);
            check_eq("sh_daddr", {32'd0, da32}, 64'h2002);
            check_eq("sh_size", {62'd0, dsz32}, 64'd1);
            check_eq("sh_strobe", {60'd0, dst32}, 64'hC);
            check_eq("sh_ddata", {32'd0, dd32}, 64'hBEEF_0000);
        end
        next_cyc();
        addr_ok = 1'b0;
        settle();
        check_eq("sh_wait_stall", {63'd0, stall32}, 64'd1);
        check_eq("sh_wait_noreq", {63'd0, dv32}, 64'd0);
        next_cyc();
        data_ok = 1'b1;
        settle();
        check_eq("sh_wait_noval", {63'd0, ov32}, 64'd0);
        next_cyc();
        idle_inputs();
        settle();
        check_eq("sh_ovalid", {63'd0, ov32}, 64'd1);
        check_eq("sh_rdata_zero", {32'd0, rd32}, 64'd0);
        next_cyc(); settle();
        check_eq("sh_pulse_end", {63'd0, ov32}, 64'd0);

        // ---------------- valid with neither read nor write
        next_cyc();
        present(1'b0, 1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
        settle();
        check_eq("nop_stall", {63'd0, stall32}, 64'd0);
        next_cyc();
        idle_inputs();
        settle();
        check_eq("nop_noval", {63'd0, ov32}, 64'd0);
        check_eq("nop_noreq", {63'd0, dv32}, 64'd0);

        // ---------------- misaligned lw / sw at 0x3001
        for (int k = 0; k < 2; k++) begin
            next_cyc();
            present(k == 0, k == 1, 1'b0, 2'd2, 32'h0000_3000, 32'd1);
            settle();
            check_eq("mis_noreq", {63'd0, dv32}, 64'd0);
            next_cyc();
            idle_inputs();
            settle();
            check_eq("mis_ovalid", {63'd0, ov32}, 64'd1);
            check_eq("mis_adel", {63'd0, adel32}, (k == 0) ? 64'd1 : 64'd0);
            check_eq("mis_ades", {63'd0, ades32}, (k == 1) ? 64'd1 : 64'd0);
            check_eq("mis_badva", {32'd0, bva32}, 64'h3001);
            check_eq("mis_rdata", {32'd0, rd32}, 64'd0);
        end

        // ---------------- flush after addr_ok -> drain; next load waits for IDLE
        next_cyc();
        present(1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_5000, 32'd0);
        next_cyc();
        addr_ok = 1'b1;
        next_cyc();
        addr_ok = 1'b0; flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        present(1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_6000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("drain_stall", {63'd0, stall32}, 64'd1);
            check_eq("drain_noreq", {63'd0, dv32}, 64'd0);
            check_eq("drain_noval", {63'd0, ov32}, 64'd0);
            next_cyc();
        end
        data_ok = 1'b1; rsp32 = 32'hDEAD_BEEF;
        settle();
        check_eq("drain_last_stall", {63'd0, stall32}, 64'd1);
        check_eq("drain_last_noreq", {63'd0, dv32}, 64'd0);
        next_cyc();
        data_ok = 1'b0;
        settle();
        check_eq("post_drain_noval", {63'd0, ov32}, 64'd0);
        check_eq("post_drain_accept", {63'd0, stall32}, 64'd1);
        check_eq("post_drain_noreq", {63'd0, dv32}, 64'd0);
        next_cyc();
        addr_ok = 1'b1; data_ok = 1'b1; rsp32 = 32'h1234_5678;
        settle();
        check_eq("new_daddr", {32'd0, da32}, 64'h6000);
        next_cyc();
        idle_inputs();
        settle();
        check_eq("new_ovalid", {63'd0, ov32}, 64'd1);
        check_eq("new_rdata", {32'd0, rd32}, 64'h1234_5678);

        // ---------------- 64-bit: lwu at 0x4004, then ld at 0x4004 (misaligned)
        next_cyc();
        present(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_4000, 32'd4);
        next_cyc();
        addr_ok = 1'b1; data_ok = 1'b1;
        rsp64 = 64'h8765_4321_0000_0000; rsp32 = 32'h0000_0000;
        settle();
        check_eq("lwu64_daddr", {32'd0, da64}, 64'h4004);
        next_cyc();
        idle_inputs();
        settle();
        check_eq("lwu64_ovalid", {63'd0, ov64}, 64'd1);
        check_eq("lwu64_rdata", rd64, 64'h0000_0000_8765_4321);
        next_cyc();
        present(1'b1, 1'b0, 1'b0, 2'd3, 32'h0000_4000, 32'd4);
        settle();
        check_eq("ld64_noreq", {63'd0, dv64}, 64'd0);
        next_cyc();
        idle_inputs();
        settle();
        check_eq("ld64_adel", {63'd0, adel64}, 64'd1);
        check_eq("ld64_badva", {32'd0, bva64}, 64'h4004);
        check_eq("ld32_size3_adel", {63'd0, adel32}, 64'd1);

        // ---------------- sd (size 3) store on 64-bit bus, sign-extended lh
        next_cyc();
        present(1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_8000, 32'd0);
        wdata64 = 64'h0102_0304_0506_0708;
        next_cyc();
        settle();
        check_eq("sd64_strobe", {56'd0, dst64}, 64'hFF);
        check_eq("sd64_ddata", dd64, 64'h0102_0304_0506_0708);
        addr_ok = 1'b1; data_ok = 1'b1;
        next_cyc();
        idle_inputs();
        next_cyc();
        present(1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_8000, 32'd6);
        next_cyc();
        addr_ok = 1'b1; data_ok = 1'b1; rsp64 = 64'h9ABC_0000_0000_0000;
        next_cyc();
        idle_inputs();
        settle();
        check_eq("lh64_rdata", rd64, 64'hFFFF_FFFF_FFFF_9ABC);

        // ---------------- reset while in WAIT; late data_ok ignored
        next_cyc();
        present(1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_7000, 32'd0);
        next_cyc();
        addr_ok = 1'b1;
        next_cyc();
        addr_ok = 1'b0; in_valid = 1'b0; in_read = 1'b0;
        settle();
        check_eq("wait_stall", {63'd0, stall32}, 64'd1);
        next_cyc();
        resetn = 1'b0;
        settle();
        check_eq("arst_stall", {63'd0, stall32}, 64'd0);
        check_eq("arst_daddr", {32'd0, da32}, 64'd0);
        check_eq("arst_dvalid", {63'd0, dv32}, 64'd0);
        check_eq("arst_ovalid", {63'd0, ov32}, 64'd0);
        check_eq("arst_badva64", {32'd0, bva64}, 64'd0);
        check_eq("arst_rdata64", rd64, 64'd0);
        next_cyc();
        resetn = 1'b1;
        data_ok = 1'b1; rsp32 = 32'hCAFE_F00D;
        settle();
        check_eq("late_dok_stall", {63'd0, stall32}, 64'd0);
        next_cyc();
        data_ok = 1'b0;
        settle();
        check_eq("late_dok_noval", {63'd0, ov32}, 64'd0);
        check_eq("late_dok_rdata", {32'd0, rd32}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Parametrised load/store access controller for the MEM stage; generalises load-data extraction to DATA_WIDTH 32 or 64.
- Adds store byte-strobe generation, alignment exceptions and a sequential dbus handshake (addr_ok/data_ok) with flush draining.
- Sits between the MEM pipeline register and the data bus. Raises stall while an access is in flight.

Parameters:
- DATA_WIDTH, 32, bus data width; 32 or 64 only. NB = DATA_WIDTH/8, LB = log2(NB).
- ADDR_WIDTH, 32, virtual/physical address width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  cancel current access (exception/branch flush from later stage)
- in_valid  in  1  MEM-stage instruction valid; held stable while stall=1
- in_read  in  1  load
- in_write  in  1  store (in_read and in_write never both 1)
- in_unsigned  in  1  zero-extend load result
- in_msize  in  2  log2 access bytes: 0=1B, 1=2B, 2=4B, 3=8B (3 legal only if DATA_WIDTH=64)
- in_base  in  ADDR_WIDTH  base register value
- in_offset  in  ADDR_WIDTH  sign-extended offset
- in_wdata  in  DATA_WIDTH  store data, right-aligned
- stall  out  1  hold MEM stage
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  DATA_WIDTH  extended load result
- out_adel  out  1  load address-alignment error, valid with out_valid
- out_ades  out  1  store address-alignment error, valid with out_valid
- out_badvaddr  out  ADDR_WIDTH  faulting address, valid with out_adel/out_ades
- dreq_valid  out  1  bus request
- dreq_addr  out  ADDR_WIDTH  request address (unaligned lane bits preserved)
- dreq_size  out  2  = captured in_msize
- dreq_strobe  out  NB  byte write enables; all 0 for loads
- dreq_data  out  DATA_WIDTH  store data shifted to lanes
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response complete
- dresp_data  in  DATA_WIDTH  read data, bus-aligned

Behaviour:
- Reset (resetn=0, async): state=IDLE; all outputs 0; captured registers cleared.
- addr = in_base + in_offset, modulo 2^ADDR_WIDTH. lane = addr[LB-1:0]. misaligned = (addr & ((1<<in_msize)-1)) != 0. in_msize=3 with DATA_WIDTH=32 is treated as misaligned.
- Accept = IDLE & in_valid & (in_read|in_write) & !flush. On accept, capture addr, size, rd/wr, unsigned and wdata.
- States:
  - IDLE:
    - accept & misaligned -> DONE with adel (load) or ades (store) and badvaddr=addr; no bus request.
    - accept & aligned -> REQ.
    - in_valid with neither read nor write -> stay IDLE, stall=0, no out_valid.
  - REQ: dreq_valid=1; addr/size/strobe/data held stable until addr_ok.
    - addr_ok&data_ok -> DONE, latch dresp_data.
    - addr_ok -> WAIT.
  - WAIT:
    - data_ok -> DONE, latch data.
  - DONE: out_valid=1 for exactly one cycle; -> IDLE.
  - DRAIN: dreq_valid=0; wait for data_ok, discard data -> IDLE.
- Flush:
  - REQ & !addr_ok -> IDLE; request withdrawn.
  - REQ&addr_ok&!data_ok, or WAIT&!data_ok -> DRAIN.
  - data_ok in the same cycle -> IDLE, data discarded.
  - DONE -> out_valid forced 0, -> IDLE.
  - DRAIN ignores flush.
- stall = accept | state∈{REQ,WAIT,DRAIN}. stall=0 in DONE, so the pipeline advances in the out_valid cycle. Total best-case latency is 2 cycles from accept to out_valid.
- Store: dreq_strobe = ((1<<(1<<size))-1) << lane, truncated to NB. dreq_data = in_wdata << (8*lane).
- Load: shifted = latched_data >> (8*lane); take low (8<<size) bits, then zero-extend if unsigned else sign-extend to DATA_WIDTH. Size equal to DATA_WIDTH is passed through unchanged.
- out_rdata = 0 for stores and exceptions.
- Response data registered at data_ok; dresp_data is never combinationally forwarded.

Test Plan:
- DW=32, lb (size0, signed), base=0x1000, offset=3, dresp_data=0x80FF_0000; addr_ok and data_ok same cycle -> dreq_addr=0x1003, strobe=0; out_rdata=0xFFFF_FF80 two cycles after accept; stall high in between.
- DW=32, sh, addr=0x2002, wdata=0x0000_BEEF -> strobe=4'b1100, dreq_data=0xBEEF_0000; addr_ok delayed 3 cycles with request fields stable throughout; data_ok 2 cycles later -> one out_valid pulse.
- lw at addr=0x3001 -> no dreq_valid; next cycle out_valid=1, out_adel=1, badvaddr=0x3001. Same for sw -> out_ades=1.
- flush one cycle after addr_ok, data_ok 4 cycles later -> DRAIN; stall=1 until data_ok; no out_valid; a new in_valid is only accepted after return to IDLE.
- DW=64, lwu at addr=0x4004, dresp_data=0x8765_4321_0000_0000 -> out_rdata=0x0000_0000_8765_4321. ld at 0x4004 -> out_adel=1.
- Assert resetn=0 during WAIT -> all outputs 0 immediately; after release, state is IDLE and a late data_ok is ignored with no out_valid.
